// File: rtl/mmcm_drp_reconfig_pkg.sv
// Shared definitions for the MMCM DRP reconfiguration block.
//   - DRP register addresses and preserve masks for the CLKFBOUT and
//     loop-filter registers.
//   - err_code encodings.
//   - FSM state encodings. The VERIFY states exist only when
//     MMCM_DRP_VERIFY_EN is defined.
//   - Helper functions that map a register index (0..3) to its address,
//     its preserve mask and its new field bits.
package mmcm_drp_reconfig_pkg;

    localparam logic [6:0]  ADDR_CLKFB1 = 7'h14;
    localparam logic [6:0]  ADDR_CLKFB2 = 7'h15;
    localparam logic [6:0]  ADDR_FILT1  = 7'h4E;
    localparam logic [6:0]  ADDR_FILT2  = 7'h4F;

    localparam logic [15:0] MASK_CLKFB1 = 16'h1000;
    localparam logic [15:0] MASK_CLKFB2 = 16'hFC00;
    localparam logic [15:0] MASK_FILT1  = 16'h66FF;
    localparam logic [15:0] MASK_FILT2  = 16'h666F;

    localparam logic [1:0]  ERR_NONE = 2'd0;
    localparam logic [1:0]  ERR_MULT = 2'd1;
    localparam logic [1:0]  ERR_DRDY = 2'd2;
    localparam logic [1:0]  ERR_LOCK = 2'd3;

    localparam logic [3:0]  ST_IDLE       = 4'd0;
    localparam logic [3:0]  ST_LUT_WAIT   = 4'd1;
    localparam logic [3:0]  ST_RST_ASSERT = 4'd2;
    localparam logic [3:0]  ST_READ       = 4'd3;
    localparam logic [3:0]  ST_WAIT_RD    = 4'd4;
    localparam logic [3:0]  ST_WRITE      = 4'd5;
    localparam logic [3:0]  ST_WAIT_WR    = 4'd6;
    localparam logic [3:0]  ST_NEXT       = 4'd7;
    localparam logic [3:0]  ST_RELEASE    = 4'd8;
    localparam logic [3:0]  ST_WAIT_LOCK  = 4'd9;
`ifdef MMCM_DRP_VERIFY_EN
    localparam logic [3:0]  ST_VERIFY     = 4'd10;
    localparam logic [3:0]  ST_WAIT_VR    = 4'd11;
`endif

    function automatic logic [6:0] reg_addr(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_addr = ADDR_CLKFB1;
            2'd1:    reg_addr = ADDR_CLKFB2;
            2'd2:    reg_addr = ADDR_FILT1;
            default: reg_addr = ADDR_FILT2;
        endcase
    endfunction

    function automatic logic [15:0] reg_mask(input logic [1:0] idx);
        case (idx)
            2'd0:    reg_mask = MASK_CLKFB1;
            2'd1:    reg_mask = MASK_CLKFB2;
            2'd2:    reg_mask = MASK_FILT1;
            default: reg_mask = MASK_FILT2;
        endcase
    endfunction

    // New field bits for register idx. The multiplier is split into high and
    // low counter times (hi = m>>1, lo = m-hi); odd multipliers set the edge
    // bit. nocnt is always 0 because m >= 2.
    function automatic logic [15:0] reg_new(input logic [1:0] idx,
                                            input logic [6:0] m,
                                            input logic [9:0] f);
        logic [6:0] h7;
        logic [6:0] l7;
        logic [5:0] hi;
        logic [5:0] lo;
        logic       edge_b;
        h7     = m >> 1;
        l7     = m - h7;
        hi     = h7[5:0];
        lo     = l7[5:0];
        edge_b = m[0];
        case (idx)
            2'd0:    reg_new = {4'b0000, hi, lo};
            2'd1:    reg_new = {8'h00, edge_b, 1'b0, 6'b000000};
            2'd2:    reg_new = {f[9], 2'b00, f[8], f[7], 2'b00, f[6], 8'h00};
            default: reg_new = {f[5], 2'b00, f[4], f[3], 2'b00, f[2], f[1], 7'h00};
        endcase
    endfunction

endpackage

// File: rtl/mmcm_drp_access.sv
// Single DRP access engine: issues one read or write and waits for drdy.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req, we           one-cycle request (ignored while an access is pending)
//   addr, wdata       access address and write data
//   ack               high in the cycle drdy returns for the pending access
//   timeout           high in the cycle the wait budget runs out
//   rdata             read data, valid with ack
//   drp_*             MMCM DRP pins
// drdy seen while no access is pending (e.g. left over from before a reset)
// is ignored.
module mmcm_drp_access #(
    parameter int DRDY_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [6:0]  addr,
    input  logic [15:0] wdata,
    output logic        ack,
    output logic        timeout,
    output logic [15:0] rdata,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
);

    localparam int CNT_W = $clog2(DRDY_TIMEOUT + 1);

    logic             pending;
    logic [CNT_W-1:0] cnt;

    assign ack     = pending & drp_drdy;
    assign timeout = pending & ~drp_drdy & (cnt == CNT_W'(DRDY_TIMEOUT - 1));
    assign rdata   = drp_do;

    always_ff @(posedge clk) begin
        if (rst) begin
            pending   <= 1'b0;
            cnt       <= '0;
            drp_den   <= 1'b0;
            drp_dwe   <= 1'b0;
            drp_daddr <= '0;
            drp_di    <= '0;
        end else begin
            drp_den <= 1'b0;
            drp_dwe <= 1'b0;
            if (req && !pending) begin
                drp_den   <= 1'b1;
                drp_dwe   <= we;
                drp_daddr <= addr;
                drp_di    <= wdata;
                pending   <= 1'b1;
                cnt       <= '0;
            end else if (pending) begin
                if (ack || timeout)
                    pending <= 1'b0;
                else
                    cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/mmcm_drp_reconfig.sv
// MMCM CLKFBOUT / loop-filter reprogramming sequencer.
// On start: validate mult, look up the filter value, hold the MMCM in reset,
// read-modify-write registers 0x14, 0x15, 0x4E, 0x4F over DRP, release the
// reset and wait for lock.
// Optional build macro MMCM_DRP_VERIFY_EN: read each register back after its
// write and abort with err_code 2 on a mismatch.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, mult         request and CLKFBOUT multiplier (2..64)
//   busy, done, err     status; done/err are one-cycle pulses
//   err_code            1 bad mult, 2 drdy timeout/verify, 3 lock timeout
//   lut_divider         address to the external filter ROM
//   lut_value           filter ROM data (one cycle after lut_divider)
//   drp_*               MMCM DRP pins
//   mmcm_rst            MMCM reset
//   mmcm_locked         MMCM lock
module mmcm_drp_reconfig
    import mmcm_drp_reconfig_pkg::*;
#(
    parameter int DRDY_TIMEOUT = 64,
    parameter int LOCK_TIMEOUT = 1048576,
    parameter int RST_HOLD     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [6:0]  mult,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [6:0]  lut_divider,
    input  logic [9:0]  lut_value,
    output logic [6:0]  drp_daddr,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy,
    output logic        mmcm_rst,
    input  logic        mmcm_locked
);

    localparam int MAX_WAIT = (LOCK_TIMEOUT > RST_HOLD) ? LOCK_TIMEOUT : RST_HOLD;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);

    logic [3:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic [6:0]       mult_r;
    logic [9:0]       filt;
    logic [15:0]      wr_val;

    logic             acc_req;
    logic             acc_we;
    logic             acc_ack;
    logic             acc_timeout;
    logic [15:0]      acc_rdata;

    always_comb begin
        acc_req = 1'b0;
        acc_we  = 1'b0;
        case (state)
            ST_READ:   acc_req = 1'b1;
            ST_WRITE: begin
                acc_req = 1'b1;
                acc_we  = 1'b1;
            end
`ifdef MMCM_DRP_VERIFY_EN
            ST_VERIFY: acc_req = 1'b1;
`endif
            default: ;
        endcase
    end

    mmcm_drp_access #(
        .DRDY_TIMEOUT(DRDY_TIMEOUT)
    ) u_access (
        .clk       (clk),
        .rst       (rst),
        .req       (acc_req),
        .we        (acc_we),
        .addr      (reg_addr(idx)),
        .wdata     (wr_val),
        .ack       (acc_ack),
        .timeout   (acc_timeout),
        .rdata     (acc_rdata),
        .drp_daddr (drp_daddr),
        .drp_den   (drp_den),
        .drp_dwe   (drp_dwe),
        .drp_di    (drp_di),
        .drp_do    (drp_do),
        .drp_drdy  (drp_drdy)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            lut_divider <= 7'd1;
            mmcm_rst    <= 1'b0;
            cnt         <= '0;
            idx         <= 2'd0;
            mult_r      <= '0;
            filt        <= '0;
            wr_val      <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (mult < 7'd2 || mult > 7'd64) begin
                            err      <= 1'b1;
                            err_code <= ERR_MULT;
                        end else begin
                            mult_r      <= mult;
                            lut_divider <= mult;
                            busy        <= 1'b1;
                            err_code    <= ERR_NONE;
                            cnt         <= '0;
                            state       <= ST_LUT_WAIT;
                        end
                    end
                end
                // ROM output is registered one cycle behind lut_divider,
                // so it is stable by the second LUT_WAIT cycle.
                ST_LUT_WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        filt     <= lut_value;
                        cnt      <= '0;
                        mmcm_rst <= 1'b1;
                        state    <= ST_RST_ASSERT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_RST_ASSERT: begin
                    if (cnt == CNT_W'(RST_HOLD - 1)) begin
                        idx   <= 2'd0;
                        state <= ST_READ;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_READ: state <= ST_WAIT_RD;
                ST_WAIT_RD: begin
                    if (acc_timeout) begin
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        mmcm_rst <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (acc_ack) begin
                        wr_val <= (acc_rdata & reg_mask(idx)) | reg_new(idx, mult_r, filt);
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: state <= ST_WAIT_WR;
                ST_WAIT_WR: begin
                    if (acc_timeout) begin
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        mmcm_rst <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (acc_ack) begin
`ifdef MMCM_DRP_VERIFY_EN
                        state <= ST_VERIFY;
`else
                        state <= ST_NEXT;
`endif
                    end
                end
`ifdef MMCM_DRP_VERIFY_EN
                ST_VERIFY: state <= ST_WAIT_VR;
                ST_WAIT_VR: begin
                    if (acc_timeout || (acc_ack && acc_rdata != wr_val)) begin
                        err      <= 1'b1;
                        err_code <= ERR_DRDY;
                        mmcm_rst <= 1'b0;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (acc_ack) begin
                        state <= ST_NEXT;
                    end
                end
`endif
                ST_NEXT: begin
                    if (idx == 2'd3) begin
                        state <= ST_RELEASE;
                    end else begin
                        idx   <= idx + 2'd1;
                        state <= ST_READ;
                    end
                end
                ST_RELEASE: begin
                    mmcm_rst <= 1'b0;
                    cnt      <= '0;
                    state    <= ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (mmcm_locked) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                        err      <= 1'b1;
                        err_code <= ERR_LOCK;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench for mmcm_drp_reconfig with a DRP slave model, a registered
// filter ROM model and a simple MMCM lock model.
module tb_mmcm_drp_reconfig;

    localparam int DRDY_TO = 64;
    localparam int LOCK_TO = 300;
    localparam int LAT     = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [6:0]  mult;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [6:0]  lut_divider;
    logic [9:0]  lut_value = '0;
    logic [6:0]  drp_daddr;
    logic        drp_den, drp_dwe;
    logic [15:0] drp_di;
    logic [15:0] drp_do = '0;
    logic        drp_drdy = 1'b0;
    logic        mmcm_rst;
    logic        mmcm_locked = 1'b0;

    int total = 0;
    int bad   = 0;

    // model controls (written only by the stimulus process)
    logic        clr = 1'b0;
    logic [15:0] fill = 16'hFFFF;
    int          hang_at = 0;
    logic        corrupt = 1'b0;
    logic        lock_en = 1'b1;
    int          lock_dly = 5;

    // model state (written only by the model processes)
    logic [6:0]  wa[$];
    logic [15:0] wd[$];
    int          n_den = 0;
    int          dly = 0;
    logic [15:0] pend_do = '0;
    int          lcnt = 0;
    logic        both_seen = 1'b0;

    always #5 clk = ~clk;

    mmcm_drp_reconfig #(
        .DRDY_TIMEOUT(DRDY_TO),
        .LOCK_TIMEOUT(LOCK_TO),
        .RST_HOLD(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mult        (mult),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .err_code    (err_code),
        .lut_divider (lut_divider),
        .lut_value   (lut_value),
        .drp_daddr   (drp_daddr),
        .drp_den     (drp_den),
        .drp_dwe     (drp_dwe),
        .drp_di      (drp_di),
        .drp_do      (drp_do),
        .drp_drdy    (drp_drdy),
        .mmcm_rst    (mmcm_rst),
        .mmcm_locked (mmcm_locked)
    );

    function automatic logic [15:0] read_val(input logic [6:0] a);
        logic [15:0] v;
        v = fill;
        foreach (wa[i]) begin
            if (wa[i] == a) begin
                v = wd[i];
                if (corrupt && a == 7'h4E) v = v ^ 16'h0001;
            end
        end
        return v;
    endfunction

    // DRP slave: answers each access LAT cycles after den, except access
    // number hang_at, which never gets drdy.
    always @(posedge clk) begin
        if (clr) begin
            wa.delete();
            wd.delete();
            n_den    <= 0;
            dly      <= 0;
            drp_drdy <= 1'b0;
        end else begin
            drp_drdy <= 1'b0;
            if (dly > 0) begin
                dly <= dly - 1;
                if (dly == 1) begin
                    drp_drdy <= 1'b1;
                    drp_do   <= pend_do;
                end
            end
            if (drp_den) begin
                n_den <= n_den + 1;
                if (drp_dwe) begin
                    wa.push_back(drp_daddr);
                    wd.push_back(drp_di);
                end else begin
                    pend_do <= read_val(drp_daddr);
                end
                if (n_den + 1 != hang_at) dly <= LAT;
            end
        end
    end

    // Filter ROM: registered, only divider 10 has a non-zero entry.
    always @(posedge clk)
        lut_value <= (lut_divider == 7'd10) ? 10'b1111011100 : 10'b0000000000;

    // MMCM lock: drops in reset, relocks lock_dly cycles after release.
    always @(posedge clk) begin
        if (mmcm_rst) begin
            mmcm_locked <= 1'b0;
            lcnt        <= 0;
        end else if (!mmcm_locked && lock_en) begin
            lcnt <= lcnt + 1;
            if (lcnt + 1 == lock_dly) mmcm_locked <= 1'b1;
        end
    end

    always @(negedge clk)
        if (done && err) both_seen <= 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_wr(input string tag, input int i, input logic [6:0] a, input logic [15:0] d);
        if (i < wa.size())
            chk(tag, {9'b0, wa[i], wd[i]}, {9'b0, a, d});
        else
            chk(tag, wa.size(), i + 1);
    endtask

    task automatic clear_model(input logic [15:0] f);
        @(negedge clk);
        clr  = 1'b1;
        fill = f;
        @(negedge clk);
        clr  = 1'b0;
    endtask

    task automatic go(input logic [6:0] m);
        @(negedge clk);
        start = 1'b1;
        mult  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_seq(input int budget, output logic gd, output logic ge);
        int c;
        gd = 1'b0;
        ge = 1'b0;
        c  = 0;
        while (c < budget && !gd && !ge) begin
            @(negedge clk);
            c++;
            gd = done;
            ge = err;
        end
        if (!gd && !ge) chk("seq_budget", c, 0);
    endtask

    logic gd, ge;
    int   n, k;
    logic flag;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mult  = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs", {1'b0, busy, done, err, err_code, mmcm_rst, drp_den, drp_dwe, drp_daddr, drp_di}, 32'h0);
        chk("reset_lutdiv", lut_divider, 1);
        rst = 1'b0;

        // mult=10, reads return 0xFFFF
        clear_model(16'hFFFF);
        go(7'd10);
        run_seq(500, gd, ge);
        chk("t1_done", gd, 1);
        chk_wr("t1_w14", 0, 7'h14, 16'h1145);
        chk_wr("t1_w15", 1, 7'h15, 16'hFC00);
        chk_wr("t1_w4e", 2, 7'h4E, 16'hFFFF);
        chk_wr("t1_w4f", 3, 7'h4F, 16'h7F6F);
        chk("t1_busy", busy, 0);

        // mult=10, reads return 0x0000
        clear_model(16'h0000);
        go(7'd10);
        run_seq(500, gd, ge);
        chk("t2_done", gd, 1);
        chk_wr("t2_w14", 0, 7'h14, 16'h0145);
        chk_wr("t2_w15", 1, 7'h15, 16'h0000);
        chk_wr("t2_w4e", 2, 7'h4E, 16'h9900);
        chk_wr("t2_w4f", 3, 7'h4F, 16'h1900);

        // mult=7 and lock timing
        clear_model(16'h0000);
        go(7'd7);
        n = 0;
        while (n < 50 && !mmcm_rst) begin @(negedge clk); n++; end
        n = 0;
        while (n < 300 && mmcm_rst) begin @(negedge clk); n++; end
        n = 0;
        while (n < 50 && !done) begin @(negedge clk); n++; end
        chk("t3_lock_lat", n, 6);
        chk("t3_busy_at_done", {busy, err}, 0);
        @(negedge clk);
        chk("t3_done_pulse", done, 0);
        chk_wr("t3_w14", 0, 7'h14, 16'h00C4);
        chk_wr("t3_w15", 1, 7'h15, 16'h0080);

        // out-of-range multipliers
        for (int j = 0; j < 2; j++) begin
            clear_model(16'h0000);
            go(j == 0 ? 7'd1 : 7'd65);
            chk("bad_mult_err", {err, err_code, busy}, {28'h0, 1'b1, 2'd1, 1'b0});
            flag = 1'b0;
            repeat (20) begin
                @(negedge clk);
                if (mmcm_rst || busy || err) flag = 1'b1;
            end
            chk("bad_mult_quiet", {flag, n_den[7:0]}, 0);
        end

        // second DRP access never answered
        clear_model(16'h0000);
        hang_at = 2;
        go(7'd10);
        n = 0;
        k = 0;
        while (k < 300 && n < 2) begin @(negedge clk); k++; if (drp_den) n++; end
        k = 0;
        while (k < 200 && !err) begin @(negedge clk); k++; end
        chk("drdy_to_lat", k, DRDY_TO);
        chk("drdy_to_code", {err_code, mmcm_rst, busy, done}, {27'h0, 2'd2, 3'b000});
        hang_at = 0;
        repeat (5) @(negedge clk);

        // reset while waiting for write drdy; drdy arrives after reset
        clear_model(16'h0000);
        go(7'd10);
        k = 0;
        while (k < 300 && !(drp_den && drp_dwe)) begin @(negedge clk); k++; end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_outs", {1'b0, busy, done, err, err_code, mmcm_rst, drp_den, drp_dwe, drp_daddr, drp_di}, 32'h0);
        chk("midrst_lutdiv", lut_divider, 1);
        repeat (6) @(negedge clk);
        chk("stale_drdy_idle", {busy, err, done, drp_den, mmcm_rst}, 0);
        clear_model(16'h0000);
        go(7'd64);
        run_seq(500, gd, ge);
        chk("m64_done", gd, 1);
        chk_wr("m64_w14", 0, 7'h14, 16'h0820);
        chk_wr("m64_w15", 1, 7'h15, 16'h0000);

        // lock never comes
        lock_en = 1'b0;
        clear_model(16'h0000);
        go(7'd10);
        run_seq(1000, gd, ge);
        chk("lock_to", {ge, gd, err_code}, {28'h0, 1'b1, 1'b0, 2'd3});
        lock_en = 1'b1;
        repeat (10) @(negedge clk);

`ifdef MMCM_DRP_VERIFY_EN
        // readback of 0x4E corrupted
        corrupt = 1'b1;
        clear_model(16'h0000);
        go(7'd10);
        run_seq(800, gd, ge);
        chk("vfy_err", {ge, gd, err_code}, {28'h0, 1'b1, 1'b0, 2'd2});
        flag = 1'b0;
        foreach (wa[i]) if (wa[i] == 7'h4F) flag = 1'b1;
        chk("vfy_no_4f", {flag, wa.size()}, 3);
        corrupt = 1'b0;
`endif

        chk("done_err_excl", both_seen, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mmcm_drp_reconfig.md
Name: mmcm_drp_reconfig

Overview:
- Downstream consumer of the PLL filter lookup ROM.
- On request, reprograms the MMCM CLKFBOUT multiplier and loop-filter bits through the DRP port, using read-modify-write on each register.
- Sequence: hold MMCM in reset, write 4 registers, release reset, wait for lock.
- Sits between host config registers and the MMCME2 DRP/reset pins.

Parameters:
- DRDY_TIMEOUT, 64, max cycles to wait for drp_drdy per access before aborting.
- LOCK_TIMEOUT, 1048576, max cycles to wait for mmcm_locked after release.
- RST_HOLD, 8, cycles mmcm_rst is held before the first DRP access.

Ports:
- clk  in  1  sole clock; DRP and lookup also run on it.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- mult  in  7  CLKFBOUT multiplier; valid range 2..64.
- busy  out  1  high from accepted start until done/err.
- done  out  1  one-cycle pulse: lock achieved.
- err  out  1  one-cycle pulse: request rejected or aborted.
- err_code  out  2  1 = bad mult, 2 = drdy timeout, 3 = lock timeout. Held until the next start.
- lut_divider  out  7  divider to filter lookup ROM.
- lut_value  in  10  filter value; registered one cycle after lut_divider.
- drp_daddr  out  7  DRP address.
- drp_den  out  1  DRP enable.
- drp_dwe  out  1  DRP write enable.
- drp_di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drp_drdy  in  1  DRP ready.
- mmcm_rst  out  1  MMCM reset.
- mmcm_locked  in  1  MMCM lock.

Behaviour:
- Reset values: all outputs 0, err_code 0, lut_divider 1. Reset mid-sequence returns to IDLE immediately with mmcm_rst=0. A stale drdy after reset is ignored.
- IDLE, on start with mult outside 2..64: err pulse next cycle, err_code=1, no DRP traffic, busy stays 0.
- IDLE, on a valid start: latch mult, drive lut_divider=mult, busy=1, go to LUT_WAIT.
- LUT_WAIT: wait 2 cycles, then capture lut_value into filt.
- Derived fields:
  - hi = mult>>1; lo = mult-hi; edge = mult[0]. All 6-bit; mult=64 gives hi=32, lo=32.
  - nocnt = 0 (mult≥2).
- Register table, as address/new/preserve-mask; final value = (drp_do & mask) | new:
  - 0x14: {3'b000, 1'b0, hi, lo}, mask 0x1000.
  - 0x15: {6'b0, 2'b00, edge, nocnt, 6'b0}, mask 0xFC00.
  - 0x4E: {f9, 2'b0, f8, f7, 2'b0, f6, 8'h00}, mask 0x66FF.
  - 0x4F: {f5, 2'b0, f4, f3, 2'b0, f2, f1, 7'h00}, mask 0x666F.
- RST_ASSERT: mmcm_rst=1, hold RST_HOLD cycles; mmcm_rst stays 1 through the DRP writes.
- Per register:
  - READ: drp_den=1 for one cycle with daddr.
  - WAIT_RD: until drdy.
  - WRITE: den=dwe=1 for one cycle with di.
  - WAIT_WR: until drdy.
  - NEXT: index++.
- drp_den never asserts while an access is outstanding.
- Each WAIT state counts; reaching DRDY_TIMEOUT gives err pulse, err_code=2, mmcm_rst=0, IDLE.
- After index 3: RELEASE deasserts mmcm_rst; WAIT_LOCK waits for mmcm_locked=1.
  - Locked: done pulse, busy=0, IDLE.
  - LOCK_TIMEOUT reached: err pulse, err_code=3.
- start while busy is ignored. done and err never assert in the same cycle.

Optional Feature:
- MMCM_DRP_VERIFY_EN defined:
  - After each WAIT_WR, add a VERIFY read (den one cycle) and WAIT_VR.
  - If drp_do ≠ written value: err pulse, err_code=2, abort sequence.
  - Adds 1 DRP read per register.
- Undefined: VERIFY states are absent; the sequence is 4 RMW accesses.

Decomposition:
- Shared package holds:
  - DRP address constants (0x14, 0x15, 0x4E, 0x4F) and their masks.
  - err_code encodings.
  - FSM state enum.
- One natural sub-module, mmcm_drp_access: a single DRP read or write with drdy wait and timeout, returning rdata/timeout. The top FSM sequences the register table through it.
- The filter ROM is instantiated by the parent, not inside this block.

Test Plan:
- mult=10, lut_value=10'b1111011100, DRP model returns 0xFFFF on every read.
  - Writes expected: 0x14←0x1145, 0x15←0xFC00, 0x4E←0xFFFF&0x66FF|0x9900=0xFFFF, 0x4F←0x7F6F|0x1900=0x7F6F.
  - Repeat with read data 0x0000: expect 0x0145, 0x0000, 0x9900, 0x1900.
- mult=7, reads 0x0000 -> 0x14←0x00C4 and 0x15←0x0080. Then locked asserted 5 cycles after release -> single done pulse, busy falls the same cycle.
- mult=1 and mult=65 -> err pulse with err_code=1, no drp_den ever asserted, mmcm_rst stays 0.
- DRP model never asserts drdy on the second access -> err after exactly DRDY_TIMEOUT wait cycles, err_code=2, mmcm_rst=0.
- rst asserted in WAIT_WR with a late drdy arriving 2 cycles after -> all outputs 0, next start(mult=64) completes normally with hi=lo=32 (0x14←0x0820 for read 0).
- With MMCM_DRP_VERIFY_EN: readback of 0x4E corrupted -> err_code=2, no write issued to 0x4F.
